// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl: frame sequencer for the 16-point parallel FFT datapath.
// Collects 16 serial complex samples into a frame buffer that drives the FFT
// inputs directly. The inputs are held for PIPE_LAT edges, then all 16 results
// are captured into an output buffer. That buffer drains one bin per beat
// while the next frame fills.
// Ports:
//   clk, rstn                          clock, async active-low reset
//   s_valid/s_ready/s_data/s_last      serial sample stream in {imag, real}
//   fft_vin                            16 x 32-bit frame to the FFT (slot n at [32n+:32])
//   fft_vout                           16 x 40-bit FFT result (bin k at [40k+:40])
//   m_valid/m_ready/m_data/m_index/m_last  bin stream out
//   frame_err                          one-cycle pulse on s_last misalignment
//   frame_cnt                          captured-frame count, wraps
//   busy                               any frame in flight
module fft16_frame_ctrl #(
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic [511:0]     fft_vin,
    input  logic [639:0]     fft_vout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [39:0]      m_data,
    output logic [3:0]       m_index,
    output logic             m_last,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam int unsigned NS = 16;
    localparam int unsigned SW = 32;
    localparam int unsigned BW = 40;
    localparam int unsigned IW = 4;
    localparam int unsigned WW = 4;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      fill_idx_q, fill_idx_d;
    logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [NS*SW-1:0]   vin_q, vin_d;
    logic [NS*BW-1:0]   obuf_q, obuf_d;
    logic               full_q, full_d;
    logic [IW-1:0]      out_idx_q, out_idx_d;
    logic               m_last_q, m_last_d;
    logic               s_ready_q, s_ready_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               busy_q, busy_d;

    logic accept_c;
    logic beat_c;
    logic last_beat_c;
    logic capture_c;

    // Handshake qualifiers; capture may reuse the buffer on its final beat.
    always_comb begin
        accept_c    = s_valid & s_ready_q;
        beat_c      = full_q & m_ready;
        last_beat_c = beat_c & (out_idx_q == IW'(NS - 1));
        capture_c   = (state_q == ST_WAIT) && (wait_cnt_q == '0) && (!full_q || last_beat_c);
    end

    // Next-state logic for fill FSM, output buffer and status outputs.
    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        wait_cnt_d  = wait_cnt_q;
        vin_d       = vin_q;
        obuf_d      = obuf_q;
        full_d      = full_q;
        out_idx_d   = out_idx_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    vin_d[SW*fill_idx_q +: SW] = s_data;
                    if (fill_idx_q == IW'(NS - 1)) begin
                        state_d    = ST_WAIT;
                        fill_idx_d = '0;
                        wait_cnt_d = WW'(PIPE_LAT - 1);
                    end else begin
                        fill_idx_d = fill_idx_q + IW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
                if (capture_c) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        // s_last only flags misalignment; the slot count is never resynchronised.
        if (accept_c) begin
            frame_err_d = (s_last != (fill_idx_q == IW'(NS - 1)));
        end

        if (beat_c) begin
            if (out_idx_q == IW'(NS - 1)) begin
                full_d    = 1'b0;
                out_idx_d = '0;
            end else begin
                out_idx_d = out_idx_q + IW'(1);
            end
        end

        // Capture after the beat update so a same-cycle refill wins.
        if (capture_c) begin
            obuf_d      = fft_vout;
            full_d      = 1'b1;
            out_idx_d   = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        s_ready_d = (state_d == ST_FILL);
        m_last_d  = (out_idx_d == IW'(NS - 1));
        busy_d    = ((state_d == ST_FILL) && (fill_idx_d != '0)) ||
                    (state_d == ST_WAIT) || full_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_FILL;
            fill_idx_q  <= '0;
            wait_cnt_q  <= '0;
            vin_q       <= '0;
            obuf_q      <= '0;
            full_q      <= 1'b0;
            out_idx_q   <= '0;
            m_last_q    <= 1'b0;
            s_ready_q   <= 1'b1;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            vin_q       <= vin_d;
            obuf_q      <= obuf_d;
            full_q      <= full_d;
            out_idx_q   <= out_idx_d;
            m_last_q    <= m_last_d;
            s_ready_q   <= s_ready_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign fft_vin   = vin_q;
    assign m_valid   = full_q;
    assign m_data    = obuf_q[BW*out_idx_q +: BW];
    assign m_index   = out_idx_q;
    assign m_last    = m_last_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule

// File: doc/fft16_frame_ctrl.md
Name: fft16_frame_ctrl

Overview:
Frame sequencer for the 16-point parallel FFT datapath. It collects 16 serial complex samples from a valid/ready stream into a frame buffer and drives them in parallel onto the FFT inputs. It holds those inputs stable for the datapath's fixed pipeline latency, captures all 16 results into an output buffer, then streams them out one bin per beat. The next frame is filled while the previous result drains.

Parameters:
PIPE_LAT, 4, clk edges from a stable FFT input change to a valid FFT output; legal range 1..15
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  32  sample {imag[15:0], real[15:0]}, two's complement
s_last  in  1  frame-end marker, used for checking only
fft_vin  out  512  frame to FFT; sample n at bits [32n+31:32n]
fft_vout  in  640  FFT result; bin k at bits [40k+39:40k] = {imag[19:0], real[19:0]}
m_valid  out  1  output bin valid
m_ready  in  1  output bin ready
m_data  out  40  output bin {imag, real}
m_index  out  4  bin number of m_data
m_last  out  1  high with bin 15
frame_err  out  1  one-cycle pulse on s_last misalignment
frame_cnt  out  CNT_W  number of frames captured, wraps
busy  out  1  any frame in flight (FILL with index>0, WAIT, or output buffer full)

Behaviour:
- Reset (async, rstn low):
  - s_ready=1, m_valid=0, m_index=0, m_last=0, frame_err=0, frame_cnt=0, busy=0.
  - fft_vin=0, fill index=0, wait counter=0, output buffer marked empty.
  - Reset mid-operation discards partial and captured frames. No output beat follows reset until a new full frame is captured.
- Input FSM states: FILL, WAIT.
  - FILL: s_ready=1. On s_valid&s_ready, write s_data to slot[fill_idx] and increment fill_idx.
  - fft_vin is the frame buffer register directly, so a write is visible after that edge.
  - Accepting slot 15 moves the FSM to WAIT, sets fill_idx=0 and loads wait_cnt=PIPE_LAT-1.
  - WAIT: s_ready=0 and fft_vin is held constant. wait_cnt decrements to 0 and holds there.
  - Capture happens at the first edge where wait_cnt==0 and the capture condition below is true. That edge is no earlier than PIPE_LAT edges after the slot-15 accept edge.
  - At capture: copy all 16 bins of fft_vout into the output buffer, set it full, increment frame_cnt, and return to FILL (s_ready=1 next cycle).
- Capture condition: output buffer empty, OR the final beat (index 15) handshakes in the same cycle.
  - In the same-cycle case, the new frame replaces the old one with no bubble. m_valid stays 1 and m_index returns to 0.
  - Otherwise WAIT holds with fft_vin stable indefinitely.
- Output side:
  - m_valid = output buffer full. m_data = bin[out_idx], m_index = out_idx, m_last = (out_idx==15). All are registered or mux-from-register; there is no combinational path from fft_vout.
  - On m_valid&m_ready: out_idx increments. When index 15 completes, the buffer becomes empty and out_idx=0.
  - m_data, m_index and m_last are stable while m_valid&!m_ready.
- Framing check:
  - frame_err pulses the cycle after an accept where s_last != (fill_idx==15).
  - The frame is still processed as exactly 16 samples; s_last never resynchronises the count.
- No width conversion or arithmetic on data; all values pass through bit-exact.
- Simultaneous input accept and output beat are independent and both allowed.

Test Plan:
1. Bench stub: fft_vout bin k = {20'(k), sign-extended real of sample k} delayed PIPE_LAT=4. Feed samples real=n*16 (n=0..15), imag=0, with m_ready held high. Required: capture 4 edges after the slot-15 accept, then 16 back-to-back beats with m_data real=0,16,...,240, imag=0..15, m_last on beat 15, frame_cnt=1.
2. Backpressure: m_ready toggles 1-0-1-0. Required: each bin is held while stalled, order is 0..15 with no duplicates, and total beats = 16.
3. Overlap: stream frame B during frame A's drain with m_ready=1/3 duty. Required: B waits in WAIT with s_ready=0 and fft_vin constant. B is captured on the same edge as A's bin-15 handshake, and B bin 0 appears the next cycle.
4. s_last on sample 7 and missing on sample 15. Required: frame_err pulses twice, and output is still exactly 16 beats with frame_cnt incremented once.
5. rstn asserted after 9 samples accepted and again during drain at bin 5. Required: all outputs return to reset values immediately, and the next full frame produces bins 0..15 correctly.
6. s_valid gaps (1 of every 3 cycles) with PIPE_LAT=1. Required: correct slot order, and capture on the edge after the slot-15 accept.
